// File: rtl/uart_fetch_bridge.sv
// uart_fetch_bridge: turns CPU word reads into a 4-byte address send and a 4-byte data receive over AXI-Stream UART links.
module uart_fetch_bridge #(
    parameter int unsigned TimeoutCycles = 1000000,
    parameter logic [31:0] NopWord = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, SEND_ADDR, RECV_DATA, RESP} state_t;
    state_t state;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cnt;
    logic [1:0] idx;
    logic [1:0] idx_n;
    logic timed_out;
    assign idx_n = idx + 2'd1;
    // cnt holds the idle cycles already spent, so expiry is on the TimeoutCycles-th idle cycle
    assign timed_out = (TimeoutCycles != 0) && (cnt == 32'(TimeoutCycles - 1));
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            addr <= '0;
            data <= '0;
            cnt <= '0;
            idx <= '0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
            m_axis_tdata <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            err_o <= 1'b0;
        end else begin
            mem_ready_o <= 1'b0;
            case (state)
                IDLE: if (mem_valid_i) begin
                    addr <= mem_addr_i;
                    idx <= '0;
                    m_axis_tdata <= mem_addr_i[7:0];
                    m_axis_tvalid <= 1'b1;
                    state <= SEND_ADDR;
                end
                SEND_ADDR: if (m_axis_tready) begin
                    idx <= idx_n;
                    m_axis_tdata <= addr[{idx_n, 3'b000} +: 8];
                    if (idx == 2'd3) begin
                        m_axis_tvalid <= 1'b0;
                        cnt <= '0;
                        state <= RECV_DATA;
                    end
                end
                RECV_DATA: if (s_axis_tvalid) begin
                    data[{idx, 3'b000} +: 8] <= s_axis_tdata;
                    idx <= idx_n;
                    cnt <= '0;
                    if (idx == 2'd3) begin
                        mem_rdata_o <= {s_axis_tdata, data[23:0]};
                        mem_ready_o <= 1'b1;
                        s_axis_tready <= 1'b0;
                        state <= RESP;
                    end
                end else if (timed_out) begin
                    mem_rdata_o <= NopWord;
                    mem_ready_o <= 1'b1;
                    s_axis_tready <= 1'b0;
                    err_o <= 1'b1;
                    state <= RESP;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                RESP: begin
                    s_axis_tready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fetch_bridge.sv
// tb_uart_fetch_bridge: random and directed fetches checked every cycle against a byte-count model of the bridge.
module tb_uart_fetch_bridge;
    localparam int TO = 50;
    localparam logic [31:0] NOP = 32'h00000013;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0] m_tdata;
    logic m_tvalid;
    logic m_tready = 1'b1;
    logic [7:0] s_tdata = '0;
    logic s_tvalid = 1'b0;
    logic s_tready;
    logic err;
    uart_fetch_bridge #(.TimeoutCycles(TO), .NopWord(NOP)) dut (
        .clk_i(clk), .reset_i(reset), .mem_valid_i(mem_valid), .mem_addr_i(mem_addr),
        .mem_ready_o(mem_ready), .mem_rdata_o(mem_rdata), .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .err_o(err)
    );
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    // model: a request is "busy" from acceptance until the response cycle; progress is just byte counts
    bit m_busy = 0, m_resp = 0, m_err = 0;
    int m_sent = 0, m_got = 0, m_idle = 0;
    logic [31:0] m_a = '0, m_rdata = '0;
    logic [7:0] m_rx [4];
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0; m_resp <= 0; m_err <= 0;
            m_sent <= 0; m_got <= 0; m_idle <= 0; m_rdata <= '0;
        end else if (m_resp) m_resp <= 0;
        else if (!m_busy) begin
            if (mem_valid) begin m_busy <= 1; m_a <= mem_addr; m_sent <= 0; m_got <= 0; end
        end else if (m_sent < 4) begin
            if (m_tready) m_sent <= m_sent + 1;
            m_idle <= 0;
        end else if (s_tvalid) begin
            m_rx[m_got] <= s_tdata;
            m_got <= m_got + 1;
            m_idle <= 0;
            if (m_got == 3) begin m_rdata <= {s_tdata, m_rx[2], m_rx[1], m_rx[0]}; m_resp <= 1; m_busy <= 0; end
        end else if (TO != 0 && m_idle + 1 == TO) begin
            m_rdata <= NOP; m_err <= 1; m_resp <= 1; m_busy <= 0;
        end else m_idle <= m_idle + 1;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    bit chk_on = 0;
    int ready_cnt = 0, ready_cyc = 0, rx_cyc = 0;
    logic [31:0] rd_seen = '0;
    logic [7:0] tx_q [$];
    always @(negedge clk) begin
        if (chk_on) begin
            check("tvalid", 32'(m_tvalid), 32'(m_busy && m_sent < 4));
            if (m_busy && m_sent < 4) check("tdata", 32'(m_tdata), 32'(8'(m_a >> (8 * m_sent))));
            check("s_tready", 32'(s_tready), 32'(!m_resp));
            check("mem_ready", 32'(mem_ready), 32'(m_resp));
            check("mem_rdata", mem_rdata, m_rdata);
            check("err", 32'(err), 32'(m_err));
        end
        if (m_tvalid && m_tready) tx_q.push_back(m_tdata);
        if (s_tvalid && s_tready) rx_cyc <= cyc;
        if (mem_ready === 1'b1) begin ready_cnt <= ready_cnt + 1; ready_cyc <= cyc; rd_seen <= mem_rdata; end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // tmode: 0 tready high, 1 toggling, 2 random; abort returns once two data bytes are in
    task automatic run_req(input logic [31:0] a, input logic [31:0] rxw, input int n_rx, input int tmode,
                           input bit hold, input bit gaps, input bit abort, output int lat);
        int rc0;
        int start;
        bit done;
        rc0 = ready_cnt;
        done = 0;
        lat = -1;
        mem_valid = 1'b1;
        mem_addr = a;
        start = cyc;
        for (int n = 0; n < 400; n++) begin
            step();
            if (ready_cnt != rc0) begin lat = ready_cyc - start + 1; done = 1; break; end
            if (abort && m_got >= 2 && m_busy) begin done = 1; break; end
            mem_valid = hold;
            mem_addr = $urandom;
            m_tready = tmode == 0 ? 1'b1 : tmode == 1 ? n[0] : 1'($urandom);
            if (m_busy && m_sent == 4) begin
                s_tvalid = m_got < n_rx && (!gaps || $urandom % 2 == 0);
                s_tdata = 8'(rxw >> (8 * m_got));
            end else begin
                s_tvalid = gaps && $urandom % 4 == 0;
                s_tdata = 8'($urandom);
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL completion: got no response, expected one for addr %h", a);
        end
    endtask
    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end
    int lat, rc, c1, c2, c3;
    initial begin
        repeat (3) step();
        reset = 1'b0;
        chk_on = 1;
        check("rst_tready", 32'(s_tready), 32'd1);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tx_q.delete();
        run_req(32'h00000008, 32'h0000a103, 4, 0, 0, 0, 0, lat);
        check("basic_lat", lat, 10);
        check("basic_rdata", rd_seen, 32'h0000a103);
        check("basic_ntx", tx_q.size(), 4);
        check("basic_tx", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'h00000008);
        tx_q.delete();
        run_req(32'h000003fc, 32'h12345678, 4, 1, 0, 0, 0, lat);
        check("toggle_ntx", tx_q.size(), 4);
        check("toggle_tx", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'h000003fc);
        check("toggle_rdata", rd_seen, 32'h12345678);
        mem_valid = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = 8'h55;
        step();
        s_tvalid = 1'b0;
        step();
        run_req(32'h00000040, 32'h3fc00093, 4, 0, 0, 0, 0, lat);
        check("stray_rdata", rd_seen, 32'h3fc00093);
        mem_valid = 1'b0;
        run_req(32'h00000080, 32'hdeadbeef, 2, 0, 0, 0, 0, lat);
        check("timeout_rdata", rd_seen, 32'h00000013);
        check("timeout_gap", ready_cyc - rx_cyc, 51);
        check("timeout_err", 32'(err), 32'd1);
        mem_valid = 1'b0;
        repeat (5) step();
        check("err_sticky", 32'(err), 32'd1);
        run_req(32'h00000100, 32'h11223344, 4, 0, 0, 0, 1, lat);
        check("err_sticky2", 32'(err), 32'd1);
        reset = 1'b1;
        s_tvalid = 1'b0;
        mem_valid = 1'b0;
        step();
        reset = 1'b0;
        rc = ready_cnt;
        repeat (20) step();
        check("abort_noready", ready_cnt, rc);
        check("abort_err", 32'(err), 32'd0);
        check("abort_rdata", mem_rdata, 32'd0);
        run_req(32'h00000200, 32'hff5ff06f, 4, 0, 0, 0, 0, lat);
        check("after_abort_rdata", rd_seen, 32'hff5ff06f);
        rc = ready_cnt;
        run_req(32'h00001000, 32'haaaa0001, 4, 0, 1, 0, 0, lat);
        c1 = ready_cyc;
        tx_q.delete();
        run_req(32'h00002004, 32'hbbbb0002, 4, 0, 1, 0, 0, lat);
        c2 = ready_cyc;
        check("hold_tx2", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'h00002004);
        check("hold_rdata2", rd_seen, 32'hbbbb0002);
        run_req(32'h00003008, 32'hcccc0003, 4, 0, 1, 0, 0, lat);
        c3 = ready_cyc;
        mem_valid = 1'b0;
        check("hold_count", ready_cnt - rc, 3);
        check("hold_gap12", c2 - c1, 10);
        check("hold_gap23", c3 - c2, 10);
        check("hold_rdata3", rd_seen, 32'hcccc0003);
        for (int i = 0; i < 250; i++) begin
            int n_rx;
            bit ab;
            n_rx = ($urandom % 8 == 0) ? int'($urandom % 4) : 4;
            ab = n_rx == 4 && $urandom % 16 == 0;
            run_req($urandom, $urandom, n_rx, int'($urandom % 3), 1'($urandom), 1'($urandom), ab, lat);
            if (ab) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            mem_valid = 1'b0;
            repeat ($urandom % 3) begin
                s_tvalid = 1'($urandom);
                s_tdata = 8'($urandom);
                step();
            end
            s_tvalid = 1'b0;
        end
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_fetch_bridge.md
UART_FETCH_BRIDGE -- requirements
Module: uart_fetch_bridge

Interface
REQ-001 SHALL have parameter: TimeoutCycles, default 1000000, RECV-state idle-cycle limit per byte; 0 disables the timeout.
REQ-002 SHALL have parameter: NopWord, default 32'h00000013, read data returned on timeout.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk_i  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port: reset_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port: mem_valid_i  input  1  CPU read request.
REQ-007 SHALL have port: mem_addr_i  input  32  byte address of request.
REQ-008 SHALL have port: mem_ready_o  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: mem_rdata_o  output  32  read word, valid while mem_ready_o=1.
REQ-010 SHALL have port: m_axis_tdata  output  8  byte to UART transmitter.
REQ-011 SHALL have port: m_axis_tvalid  output  1  tx byte valid.
REQ-012 SHALL have port: m_axis_tready  input  1  UART transmitter accepts byte.
REQ-013 SHALL have port: s_axis_tdata  input  8  byte from UART receiver.
REQ-014 SHALL have port: s_axis_tvalid  input  1  rx byte valid.
REQ-015 SHALL have port: s_axis_tready  output  1  bridge accepts rx byte.
REQ-016 SHALL have port: err_o  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, SEND_ADDR, RECV_DATA, RESP.
REQ-018 IDLE: on mem_valid_i=1 SHALL latch mem_addr_i, clear byte index, enter SEND_ADDR next cycle.
REQ-019 SEND_ADDR: m_axis_tvalid=1; m_axis_tdata = latched address byte[index], LSB first (bits 7:0, 15:8, 23:16, 31:24).
REQ-020 Byte transfer SHALL occur only on cycles with m_axis_tvalid=1 and m_axis_tready=1; index increments per transfer; tdata held stable while tready=0.
REQ-021 After 4th address byte accepted, SHALL enter RECV_DATA with index=0 and timeout counter=0; m_axis_tvalid=0 outside SEND_ADDR.
REQ-022 RECV_DATA: each s_axis_tvalid&s_axis_tready cycle SHALL store s_axis_tdata into rdata byte[index], LSB first, and increment index.
REQ-023 After 4th data byte, SHALL enter RESP; mem_ready_o=1 for exactly one cycle with assembled word on mem_rdata_o.
REQ-024 RESP SHALL always return to IDLE next cycle; a new request SHALL not be accepted in the RESP cycle.
REQ-025 s_axis_tready SHALL be 1 in IDLE, SEND_ADDR, RECV_DATA and 0 in RESP; bytes accepted outside RECV_DATA SHALL be discarded.
REQ-026 Timeout counter SHALL count cycles in RECV_DATA, clear on each received byte; on reaching TimeoutCycles (if nonzero) SHALL enter RESP with mem_rdata_o=NopWord and set err_o.
REQ-027 Deassertion of mem_valid_i after acceptance SHALL not abort the transaction; completion pulse still issued.
REQ-028 Minimum request latency SHALL be 10 cycles (accept, 4 tx, 4 rx, RESP) with zero backpressure.
REQ-029 mem_addr_i changes after acceptance SHALL not affect transmitted bytes.
REQ-030 mem_rdata_o SHALL hold last returned value outside RESP.

Reset
REQ-031 On reset_i=1 at a clock edge: state=IDLE, index=0, timeout counter=0, mem_ready_o=0, mem_rdata_o=0, m_axis_tvalid=0, m_axis_tdata=0, err_o=0; s_axis_tready=1 from the first cycle after reset.
REQ-032 Reset mid-transaction SHALL abandon it with no mem_ready_o pulse; partial bytes discarded.

Verification
REQ-033 Addr 0x00000008, tready=1, rx bytes 03,a1,00,00 -> tx bytes 08,00,00,00; mem_ready_o one cycle, mem_rdata_o=0x0000a103, latency 10 cycles.
REQ-034 Addr 0x000003fc, m_axis_tready toggling every other cycle -> tx bytes fc,03,00,00 in order, each held stable until accepted; no duplicates.
REQ-035 Stray rx byte 0x55 in IDLE, then request with rx 93,00,c0,3f -> 0x55 dropped; mem_rdata_o=0x3fc00093.
REQ-036 TimeoutCycles=50, only 2 rx bytes after address -> mem_ready_o at 50 cycles after last byte, mem_rdata_o=0x00000013, err_o=1 until reset.
REQ-037 reset_i asserted after 2nd rx byte -> no mem_ready_o; next request with rx 6f,f0,5f,ff returns 0xff5ff06f.
REQ-038 mem_valid_i held high continuously across 3 requests -> 3 distinct transactions, one mem_ready_o pulse each, IDLE acceptance the cycle after each RESP.
